seg_scan_drv: RTL

- Output-side counterpart of the switch/key capture stage in the calculator.
- Takes the two captured operands and the 8-bit result/indicator value, and drives a 4-digit, common-anode, multiplexed 7-segment display.
- Segment and digit lines are active-low, matching the board's inverted I/O.
- Provides frame-synchronous double buffering, an inter-digit blanking gap against ghosting, and optional leading-zero suppression.

---
 rtl/seg_scan_drv_if.sv | 22 ++
 rtl/seg_scan_drv.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_drv_if.sv
// Operand/indicator input bundle and multiplexed 7-segment output lines for seg_scan_drv.
interface seg_scan_drv_if;
    logic [3:0] op_1;
    logic [3:0] op_2;
    logic [7:0] ind;
    logic [3:0] dp_mask;
    logic       lz_en;
    logic       load;
    logic [7:0] seg_n;
    logic [3:0] dig_n;
    logic       frame_done;

    modport master (
        output op_1, op_2, ind, dp_mask, lz_en, load,
        input  seg_n, dig_n, frame_done
    );

    modport slave (
        input  op_1, op_2, ind, dp_mask, lz_en, load,
        output seg_n, dig_n, frame_done
    );
endinterface

// File: rtl/seg_scan_drv.sv
// 4-digit common-anode 7-segment scan driver with frame-synchronous double buffering,
// inter-digit blanking and optional leading-zero suppression on digit 1.
module seg_scan_drv #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic           clk_scan,
    input  logic           rst_n,
    seg_scan_drv_if.slave  bus
);
    localparam int unsigned MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0] op_1;
        logic [3:0] op_2;
        logic [7:0] ind;
        logic [3:0] dp_mask;
        logic       lz_en;
    } disp_buf_t;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    disp_buf_t          shadow_q, shadow_d;
    disp_buf_t          disp_q, disp_d;
    logic               pending_q, pending_d;
    logic [7:0]         seg_q, seg_d;
    logic [3:0]         dig_q, dig_d;
    logic               fd_q, fd_d;

    logic               boundary;
    logic [3:0]         nib;
    logic               dp_on;
    logic               suppress;

    // Active-low a..g pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            default: p = 7'h0E;
        endcase
        return p;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        fd_d      = 1'b0;
        boundary  = 1'b0;
        seg_d     = 8'hFF;
        dig_d     = 4'hF;
        nib       = 4'h0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
                    state_d  = ST_SHOW;
                    cnt_d    = '0;
                    boundary = (idx_q == IDX_W'(0));
                end
            end
            ST_SHOW: begin
                if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        if (boundary && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
            fd_d      = 1'b1;
        end

        // A load on the boundary cycle lands in the shadow and waits for the next frame.
        if (bus.load) begin
            shadow_d  = '{op_1: bus.op_1, op_2: bus.op_2, ind: bus.ind,
                          dp_mask: bus.dp_mask, lz_en: bus.lz_en};
            pending_d = 1'b1;
        end

        case (idx_d)
            2'd0:    nib = disp_d.ind[3:0];
            2'd1:    nib = disp_d.ind[7:4];
            2'd2:    nib = disp_d.op_2;
            default: nib = disp_d.op_1;
        endcase
        dp_on    = disp_d.dp_mask[idx_d];
        suppress = (idx_d == IDX_W'(1)) && disp_d.lz_en && (disp_d.ind[7:4] == 4'h0);

        // Outputs are computed from the next state so they change on the entering edge.
        if (state_d == ST_SHOW) begin
            dig_d = ~(4'b0001 << idx_d);
            if (!suppress) begin
                seg_d = {~dp_on, hex7(nib)};
            end
        end
    end

    always_ff @(posedge clk_scan or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            seg_q     <= 8'hFF;
            dig_q     <= 4'hF;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
            fd_q      <= fd_d;
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.dig_n      = dig_q;
    assign bus.frame_done = fd_q;
endmodule
